// File: rtl/seq_alu.sv
// seq_alu: clocked calculator ALU with a start/busy/done handshake and status flags.
// Add, subtract and the logic ops finish in one execute cycle. Unsigned multiply
// (shift-add, LSB first) and divide (restoring, MSB first) take WIDTH iterations.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    // The iteration states spend counts 0..WIDTH-1 on the bit steps and count
    // WIDTH on committing the result, which is why the counter must reach WIDTH.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL_IT,
        DIV_IT,
        FIN
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;

    // Operands captured at acceptance; later changes on a/b/sel are ignored.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       sel_reg;

    // Shared iteration registers.
    // MUL: work_hi = partial product high half, work_lo = multiplier shifting out / product low half.
    // DIV: work_hi = partial remainder, work_lo = dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] exec_y;
    logic [WIDTH-1:0] exec_hi;
    logic             exec_carry;
    logic             exec_ovf;
    logic             exec_dz;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign accept = (state_reg == IDLE) && start;

    // State register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == MUL_IT) || (state_reg == DIV_IT)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // Next-state selection and handshake outputs decoded from the state.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (sel == OP_MUL) begin
                        state_next = MUL_IT;
                    end else if ((sel == OP_DIV) && (b != '0)) begin
                        state_next = DIV_IT;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                busy       = 1'b1;
                state_next = FIN;
            end
            MUL_IT, DIV_IT: begin
                busy = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result and flags for the EXEC path (includes divide by zero).
    always_comb begin
        add_full   = {1'b0, a_reg} + {1'b0, b_reg};
        sub_res    = a_reg - b_reg;
        exec_y     = '0;
        exec_hi    = '0;
        exec_carry = 1'b0;
        exec_ovf   = 1'b0;
        exec_dz    = 1'b0;
        case (sel_reg)
            OP_ADD: begin
                exec_y     = add_full[WIDTH-1:0];
                exec_carry = add_full[WIDTH];
                exec_ovf   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (add_full[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                exec_y     = sub_res;
                exec_carry = (a_reg < b_reg);
                exec_ovf   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                             (sub_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_AND: exec_y = a_reg & b_reg;
            OP_OR:  exec_y = a_reg | b_reg;
            OP_XOR: exec_y = a_reg ^ b_reg;
            OP_NOT: exec_y = ~a_reg;
            OP_DIV: begin
                // Only reached here when the divisor is zero.
                exec_y  = '1;
                exec_hi = a_reg;
                exec_dz = 1'b1;
            end
            default: exec_y = '0;
        endcase
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_add   = work_lo[0] ? a_reg : '0;
        mul_sum   = {1'b0, work_hi} + {1'b0, mul_add};
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_reg) : div_shift[WIDTH-1:0];
    end

    // Operand capture, iteration datapath and registered results/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sel_reg <= '0;
            work_hi <= '0;
            work_lo <= '0;
            y       <= '0;
            y_hi    <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sel_reg <= sel;
                        work_hi <= '0;
                        work_lo <= (sel == OP_MUL) ? b : a;
                    end
                end
                EXEC: begin
                    y     <= exec_y;
                    y_hi  <= exec_hi;
                    zero  <= (exec_y == '0);
                    carry <= exec_carry;
                    ovf   <= exec_ovf;
                    dz    <= exec_dz;
                end
                MUL_IT: begin
                    if (cnt_reg != LAST_CNT) begin
                        work_hi <= mul_sum[WIDTH:1];
                        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    end else begin
                        y     <= work_lo;
                        y_hi  <= work_hi;
                        zero  <= ({work_hi, work_lo} == '0);
                        carry <= 1'b0;
                        ovf   <= (work_hi != '0);
                        dz    <= 1'b0;
                    end
                end
                DIV_IT: begin
                    if (cnt_reg != LAST_CNT) begin
                        work_hi <= div_rem;
                        work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    end else begin
                        y     <= work_lo;
                        y_hi  <= work_hi;
                        zero  <= (work_lo == '0);
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        dz    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: drives an 8-bit and a 16-bit seq_alu side by side and checks
// results, flags, latency and handshake against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  sel = 3'b000;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic [7:0]  y8, yh8;
    logic [15:0] y16, yh16;
    logic        busy8, done8, z8, c8, o8, d8;
    logic        busy16, done16, z16, c16, o16, d16;

    int vectors = 0;
    int miscompares = 0;

    seq_alu #(.WIDTH(8), .CNT_W(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a8), .b(b8), .sel(sel),
        .y(y8), .y_hi(yh8), .busy(busy8), .done(done8),
        .zero(z8), .carry(c8), .ovf(o8), .dz(d8)
    );

    seq_alu #(.WIDTH(16), .CNT_W(6)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a16), .b(b16), .sel(sel),
        .y(y16), .y_hi(yh16), .busy(busy16), .done(done16),
        .zero(z16), .carry(c16), .ovf(o16), .dz(d16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on a w-bit machine.
    // fl = {zero, carry, ovf, dz}; lat = cycles from accept edge to done.
    function automatic void model(input int w, input logic [2:0] s,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned y, output longint unsigned yh,
                                  output logic [3:0] fl, output int lat);
        longint unsigned full, mask, p;
        longint sa, sb, r, smax, smin;
        logic z, c, o, d;
        full = 64'd1 << w;
        mask = full - 1;
        smax = longint'(full / 2) - 1;
        smin = -longint'(full / 2);
        sa = (a >= full / 2) ? longint'(a) - longint'(full) : longint'(a);
        sb = (b >= full / 2) ? longint'(b) - longint'(full) : longint'(b);
        y = 0; yh = 0; c = 0; o = 0; d = 0; lat = 2;
        case (s)
            3'd0: begin
                y = (a + b) & mask; c = ((a + b) >> w) != 0;
                r = sa + sb; o = (r > smax) || (r < smin);
            end
            3'd1: begin
                y = (a - b) & mask; c = (a < b);
                r = sa - sb; o = (r > smax) || (r < smin);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = (~a) & mask;
            3'd6: begin
                p = a * b; y = p & mask; yh = p >> w; o = (yh != 0); lat = w + 2;
            end
            default: begin
                if (b == 0) begin
                    y = mask; yh = a; d = 1;
                end else begin
                    y = a / b; yh = a % b; lat = w + 2;
                end
            end
        endcase
        z = (s == 3'd6) ? ((y == 0) && (yh == 0)) : (y == 0);
        fl = {z, c, o, d};
    endfunction

    // One operation on both DUTs. Operands and opcode are scrambled right after
    // acceptance; with intr, an ADD start is pulsed at cycle 3 and must be ignored.
    task automatic do_op(input logic [2:0] s, input longint unsigned va8, input longint unsigned vb8,
                         input longint unsigned va16, input longint unsigned vb16, input bit intr);
        longint unsigned ey8, eh8, ey16, eh16;
        logic [3:0] ef8, ef16;
        int el8, el16, lat8, lat16, nd8, nd16;
        model(8, s, va8, vb8, ey8, eh8, ef8, el8);
        model(16, s, va16, vb16, ey16, eh16, ef16, el16);
        lat8 = 0; lat16 = 0; nd8 = 0; nd16 = 0;
        @(negedge clk);
        sel = s; a8 = va8[7:0]; b8 = vb8[7:0]; a16 = va16[15:0]; b16 = vb16[15:0];
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom);
                a16 = 16'($urandom); b16 = 16'($urandom);
                sel = 3'($urandom);
                chk("busy8_after_accept", 64'(busy8), 64'd1);
                chk("busy16_after_accept", 64'(busy16), 64'd1);
            end
            if (intr && k == 3) begin
                start = 1'b1; sel = 3'b000;
            end
            if (intr && k == 4) start = 1'b0;
            if (done8) begin
                nd8++;
                if (lat8 == 0) lat8 = k;
            end
            if (done16) begin
                nd16++;
                if (lat16 == 0) lat16 = k;
            end
        end
        $display("op sel=%0d a8=%0h b8=%0h -> y=%0h yh=%0h f=%b lat=%0d | a16=%0h b16=%0h -> y=%0h yh=%0h f=%b lat=%0d",
                 s, va8, vb8, y8, yh8, {z8, c8, o8, d8}, lat8, va16, vb16, y16, yh16, {z16, c16, o16, d16}, lat16);
        chk("done_count8", 64'(nd8), 64'd1);
        chk("done_count16", 64'(nd16), 64'd1);
        chk("latency8", 64'(lat8), 64'(el8));
        chk("latency16", 64'(lat16), 64'(el16));
        chk("y8", 64'(y8), ey8);
        chk("y_hi8", 64'(yh8), eh8);
        chk("flags8", 64'({z8, c8, o8, d8}), 64'(ef8));
        chk("y16", 64'(y16), ey16);
        chk("y_hi16", 64'(yh16), eh16);
        chk("flags16", 64'({z16, c16, o16, d16}), 64'(ef16));
    endtask

    initial begin
        int nd8, nd16;
        logic [2:0] rs;
        longint unsigned ra8, rb8, ra16, rb16;

        // Reset held for three cycles, then idle with all outputs cleared.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nd8 = 0; nd16 = 0;
        repeat (4) begin
            @(negedge clk);
            if (done8) nd8++;
            if (done16) nd16++;
        end
        chk("reset_out8", 64'({y8, yh8, busy8, z8, c8, o8, d8}), 64'd0);
        chk("reset_out16", 64'({y16, yh16, busy16, z16, c16, o16, d16}), 64'd0);
        chk("reset_no_done", 64'(nd8 + nd16), 64'd0);

        // Directed vectors.
        do_op(3'd0, 200, 100, 200, 100, 0);
        do_op(3'd1, 5, 7, 5, 7, 0);
        do_op(3'd1, 8'h80, 8'h01, 16'h8000, 16'h0001, 0);
        do_op(3'd6, 15, 17, 15, 17, 0);
        do_op(3'd6, 255, 255, 16'hFFFF, 16'hFFFF, 0);
        do_op(3'd6, 0, 99, 0, 99, 0);
        do_op(3'd7, 200, 7, 200, 7, 0);
        do_op(3'd7, 9, 0, 9, 0, 0);
        do_op(3'd7, 3, 200, 3, 16'd50000, 0);
        do_op(3'd5, 8'h00, 8'h12, 16'h0000, 16'h1234, 0);
        do_op(3'd0, 127, 1, 16'h7FFF, 1, 0);

        // A second start while multiplying is dropped; the MUL result stands.
        do_op(3'd6, 77, 201, 1234, 4321, 1);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            rs = 3'($urandom_range(7));
            ra8 = 64'($urandom_range(255)); rb8 = 64'($urandom_range(255));
            ra16 = 64'($urandom_range(65535)); rb16 = 64'($urandom_range(65535));
            if ($urandom_range(7) == 0) begin
                rb8 = 0; rb16 = 0;
            end
            do_op(rs, ra8, rb8, ra16, rb16, 0);
        end

        // Start held high: ADD re-triggers every three cycles, done at 2,5,...,29.
        @(negedge clk);
        sel = 3'd0; a8 = 8'd3; b8 = 8'd4; a16 = 16'd3; b16 = 16'd4; start = 1'b1;
        nd8 = 0; nd16 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) nd8++;
            if (done16) nd16++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        $display("held start: dones8=%0d dones16=%0d y8=%0h", nd8, nd16, y8);
        chk("held_done_count8", 64'(nd8), 64'd10);
        chk("held_done_count16", 64'(nd16), 64'd10);
        chk("held_y8", 64'(y8), 64'd7);

        // Reset pulsed in cycle 5 of a MUL aborts it without a done.
        @(negedge clk);
        sel = 3'd6; a8 = 8'd200; b8 = 8'd201; a16 = 16'd999; b16 = 16'd777; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        $display("reset mid-MUL: busy8=%0b y8=%0h busy16=%0b y16=%0h", busy8, y8, busy16, y16);
        chk("abort_out8", 64'({y8, yh8, busy8, done8, z8, c8, o8, d8}), 64'd0);
        chk("abort_out16", 64'({y16, yh16, busy16, done16, z16, c16, o16, d16}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd8 = 0; nd16 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done8) nd8++;
            if (done16) nd16++;
        end
        chk("abort_no_done", 64'(nd8 + nd16), 64'd0);
        chk("abort_idle_busy", 64'({busy8, busy16}), 64'd0);

        // The block works normally after the abort.
        do_op(3'd7, 250, 3, 60000, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
